// File: rtl/fp_addsub_seq.sv
// Multi-cycle IEEE-754 single-precision add/subtract sequencer.
// Accepts one operand pair, aligns and normalises iteratively (one shift per
// cycle), truncates instead of rounding, and holds the packed result until taken.
module fp_addsub_seq (
   input  logic        clk,
   input  logic        rstn,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] num1,
   input  logic [31:0] num2,
   input  logic        sel2,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] result,
   output logic        busy
);

   localparam int unsigned WORD_W = 32;
   localparam int unsigned EXP_W  = 8;
   localparam int unsigned FRAC_W = 23;
   localparam int unsigned MANT_W = 24;
   localparam int unsigned SUM_W  = 25;

   localparam logic [WORD_W-1:0] QNAN        = 32'h7FC0_0000;
   localparam logic [EXP_W-1:0]  EXP_MAX     = 8'hFF;
   localparam logic [EXP_W-1:0]  EXP_TOP     = 8'hFE;
   localparam logic [EXP_W-1:0]  ALIGN_FLUSH = 8'd26;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ALIGN = 3'd1,
      ST_ADD   = 3'd2,
      ST_NORM  = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   state_t              state_q, state_d;
   logic                in_ready_q, in_ready_d;
   logic                out_valid_q, out_valid_d;
   logic                busy_q, busy_d;
   logic [WORD_W-1:0]   result_q, result_d;
   logic [EXP_W-1:0]    exp_q, exp_d;
   logic [EXP_W-1:0]    diff_q, diff_d;
   logic [MANT_W-1:0]   mant_b_q, mant_b_d;
   logic [MANT_W-1:0]   mant_s_q, mant_s_d;
   logic                sign_b_q, sign_b_d;
   logic                sign_s_q, sign_s_d;
   logic [SUM_W-1:0]    sum_q, sum_d;
   logic                sign_q, sign_d;

   // Operand unpack; a zero exponent flushes the whole operand to zero
   logic [EXP_W-1:0]    exp1, exp2;
   logic [MANT_W-1:0]   mant1, mant2;
   logic                sgn1, sgn2;
   logic                nan1, nan2, inf1, inf2, special;
   logic [WORD_W-1:0]   special_res;
   logic                accept;

   assign exp1    = num1[30:23];
   assign exp2    = num2[30:23];
   assign mant1   = (exp1 != '0) ? {1'b1, num1[FRAC_W-1:0]} : '0;
   assign mant2   = (exp2 != '0) ? {1'b1, num2[FRAC_W-1:0]} : '0;
   assign sgn1    = num1[31];
   assign sgn2    = num2[31] ^ sel2;
   assign nan1    = (exp1 == EXP_MAX) && (num1[FRAC_W-1:0] != '0);
   assign nan2    = (exp2 == EXP_MAX) && (num2[FRAC_W-1:0] != '0);
   assign inf1    = (exp1 == EXP_MAX) && (num1[FRAC_W-1:0] == '0);
   assign inf2    = (exp2 == EXP_MAX) && (num2[FRAC_W-1:0] == '0);
   assign special = (exp1 == EXP_MAX) || (exp2 == EXP_MAX);
   assign accept  = in_valid && in_ready_q;

   // Result for NaN / infinity operands, using the effective sign of B
   always_comb begin
      special_res = QNAN;
      if (nan1 || nan2) begin
         special_res = QNAN;
      end else if (inf1 && inf2 && (sgn1 != sgn2)) begin
         special_res = QNAN;
      end else if (inf1) begin
         special_res = {sgn1, EXP_MAX, FRAC_W'(0)};
      end else begin
         special_res = {sgn2, EXP_MAX, FRAC_W'(0)};
      end
   end

   // Next-state and datapath update for the sequencer
   always_comb begin
      state_d  = state_q;
      result_d = result_q;
      exp_d    = exp_q;
      diff_d   = diff_q;
      mant_b_d = mant_b_q;
      mant_s_d = mant_s_q;
      sign_b_d = sign_b_q;
      sign_s_d = sign_s_q;
      sum_d    = sum_q;
      sign_d   = sign_q;

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (exp2 > exp1) begin
                  exp_d    = exp2;
                  diff_d   = exp2 - exp1;
                  mant_b_d = mant2;
                  sign_b_d = sgn2;
                  mant_s_d = mant1;
                  sign_s_d = sgn1;
               end else begin
                  exp_d    = exp1;
                  diff_d   = exp1 - exp2;
                  mant_b_d = mant1;
                  sign_b_d = sgn1;
                  mant_s_d = mant2;
                  sign_s_d = sgn2;
               end
               if (special) begin
                  result_d = special_res;
                  state_d  = ST_DONE;
               end else begin
                  state_d  = ST_ALIGN;
               end
            end
         end

         ST_ALIGN: begin
            if (diff_q >= ALIGN_FLUSH) begin
               mant_s_d = '0;
               diff_d   = '0;
            end else if (diff_q != '0) begin
               mant_s_d = mant_s_q >> 1;
               diff_d   = diff_q - 8'd1;
            end else begin
               state_d  = ST_ADD;
            end
         end

         ST_ADD: begin
            if (sign_b_q == sign_s_q) begin
               sum_d  = {1'b0, mant_b_q} + {1'b0, mant_s_q};
               sign_d = sign_b_q;
            end else if (mant_b_q > mant_s_q) begin
               sum_d  = {1'b0, mant_b_q - mant_s_q};
               sign_d = sign_b_q;
            end else if (mant_s_q > mant_b_q) begin
               sum_d  = {1'b0, mant_s_q - mant_b_q};
               sign_d = sign_s_q;
            end else begin
               sum_d  = '0;
               sign_d = 1'b0;
            end
            state_d = ST_NORM;
         end

         ST_NORM: begin
            if (sum_q == '0) begin
               result_d = '0;
               state_d  = ST_DONE;
            end else if (sum_q[24]) begin
               sum_d = {1'b0, sum_q[SUM_W-1:1]};
               exp_d = exp_q + 8'd1;
               if (exp_q == EXP_TOP) begin
                  result_d = {sign_q, EXP_MAX, FRAC_W'(0)};
                  state_d  = ST_DONE;
               end
            end else if (!sum_q[23]) begin
               if (exp_q > 8'd1) begin
                  sum_d = {sum_q[SUM_W-2:0], 1'b0};
                  exp_d = exp_q - 8'd1;
               end else begin
                  result_d = {sign_q, 31'(0)};
                  state_d  = ST_DONE;
               end
            end else begin
               result_d = {sign_q, exp_q, sum_q[FRAC_W-1:0]};
               state_d  = ST_DONE;
            end
         end

         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      in_ready_d  = (state_d == ST_IDLE);
      out_valid_d = (state_d == ST_DONE);
      busy_d      = (state_d != ST_IDLE);
   end

   // State, datapath and registered handshake outputs
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= ST_IDLE;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         result_q    <= '0;
         exp_q       <= '0;
         diff_q      <= '0;
         mant_b_q    <= '0;
         mant_s_q    <= '0;
         sign_b_q    <= 1'b0;
         sign_s_q    <= 1'b0;
         sum_q       <= '0;
         sign_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
         result_q    <= result_d;
         exp_q       <= exp_d;
         diff_q      <= diff_d;
         mant_b_q    <= mant_b_d;
         mant_s_q    <= mant_s_d;
         sign_b_q    <= sign_b_d;
         sign_s_q    <= sign_s_d;
         sum_q       <= sum_d;
         sign_q      <= sign_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign result    = result_q;

endmodule

// File: tb/tb_fp_addsub_seq.sv
// Bench for fp_addsub_seq: directed cases plus random operands against an
// integer-arithmetic reference of truncating single-precision add/subtract.
module tb_fp_addsub_seq;

   logic        clk = 1'b0;
   logic        rstn = 1'b1;
   logic        in_valid = 1'b0;
   logic        sel2 = 1'b0;
   logic        out_ready = 1'b0;
   logic [31:0] num1 = '0;
   logic [31:0] num2 = '0;
   logic        in_ready;
   logic        out_valid;
   logic        busy;
   logic [31:0] result;

   int checks = 0;
   int passed = 0;

   fp_addsub_seq dut (
      .clk       (clk),
      .rstn      (rstn),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .num1      (num1),
      .num2      (num2),
      .sel2      (sel2),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .busy      (busy)
   );

   initial forever #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) begin
         passed++;
      end else begin
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: exact integer alignment by truncating division, signed sum,
   // then normalisation by magnitude; also derives the cycle count.
   function automatic void ref_model(input logic [31:0] a, input logic [31:0] b, input logic sel,
                                     output logic [31:0] r, output int lat);
      int     ea, eb, eg, es, d, e, nc, acyc;
      logic   sa, sb, s, na, nb;
      longint ma, mb, vg, vs, t, mag;
      ea = int'(a[30:23]);
      eb = int'(b[30:23]);
      sa = a[31];
      sb = b[31] ^ sel;
      ma = (ea == 0) ? 64'sd0 : longint'({1'b1, a[22:0]});
      mb = (eb == 0) ? 64'sd0 : longint'({1'b1, b[22:0]});
      if (ea == 255 || eb == 255) begin
         lat = 1;
         na = (ea == 255) && (a[22:0] != 0);
         nb = (eb == 255) && (b[22:0] != 0);
         if (na || nb) r = 32'h7FC0_0000;
         else if (ea == 255 && eb == 255 && sa != sb) r = 32'h7FC0_0000;
         else if (ea == 255) r = {sa, 8'hFF, 23'd0};
         else r = {sb, 8'hFF, 23'd0};
         return;
      end
      if (eb > ea) begin
         eg = eb; es = ea; vg = sb ? -mb : mb; vs = sa ? -ma : ma;
      end else begin
         eg = ea; es = eb; vg = sa ? -ma : ma; vs = sb ? -mb : mb;
      end
      d    = eg - es;
      acyc = (d <= 25) ? d : 1;
      vs   = (d >= 26) ? 64'sd0 : vs / (64'sd1 <<< d);
      t    = vg + vs;
      e    = eg;
      nc   = 1;
      r    = '0;
      if (t == 0) begin
         lat = acyc + 3 + nc;
         return;
      end
      s   = (t < 0);
      mag = s ? -t : t;
      while (1'b1) begin
         if (mag >= (64'sd1 <<< 24)) begin
            mag = mag / 2;
            e   = e + 1;
            if (e == 255) begin
               r = {s, 8'hFF, 23'd0};
               break;
            end
            nc++;
         end else if (mag < (64'sd1 <<< 23)) begin
            if (e > 1) begin
               mag = mag * 2;
               e   = e - 1;
               nc++;
            end else begin
               r = {s, 31'd0};
               break;
            end
         end else begin
            r = {s, 8'(e), 23'(mag)};
            break;
         end
      end
      lat = acyc + 3 + nc;
   endfunction

   function automatic logic [31:0] rand_fp(input int base);
      int   r, e;
      logic s;
      r = int'($urandom_range(0, 99));
      s = 1'($urandom_range(0, 1));
      if (r < 4) return {s, 8'hFF, 23'd0};
      if (r < 6) return {s, 8'hFF, 23'($urandom) | 23'd1};
      if (r < 10) return {s, 31'd0};
      if (r < 25) e = int'($urandom_range(1, 254));
      else e = base + int'($urandom_range(0, 40)) - 20;
      if (e < 1) e = 1;
      if (e > 254) e = 254;
      return {s, 8'(e), 23'($urandom)};
   endfunction

   task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic sel);
      for (int i = 0; i < 100; i++) begin
         if (in_ready) break;
         @(negedge clk);
      end
      num1     = a;
      num2     = b;
      sel2     = sel;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic wait_result(output int lat);
      lat = 0;
      for (int c = 1; c <= 80; c++) begin
         @(negedge clk);
         if (out_valid) begin
            lat = c;
            break;
         end
      end
   endtask

   task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic sel, input logic [31:0] exp_r, input int exp_lat);
      int lat;
      out_ready = 1'b1;
      @(negedge clk);
      start_op(a, b, sel);
      wait_result(lat);
      check({tag, "_res"}, 64'(result), 64'(exp_r));
      check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
      @(negedge clk);
      check({tag, "_consumed"}, 64'({out_valid, busy, in_ready}), 64'(3'b001));
   endtask

   initial begin
      logic [31:0] ra, rb, rr, held;
      logic        rs;
      int          rl, lat, base;
      logic        seen;

      // Reset state
      #2 rstn = 1'b0;
      #20;
      check("reset_outputs", 64'({out_valid, busy, in_ready, result}), 64'({3'b001, 32'h0}));
      @(negedge clk);
      rstn = 1'b1;

      // Directed cases
      run_op("one_plus_one",   32'h3F80_0000, 32'h3F80_0000, 1'b0, 32'h4000_0000, 5);
      run_op("three_minus_one",32'h4040_0000, 32'h3F80_0000, 1'b1, 32'h4000_0000, 5);
      run_op("cancel",         32'h3F80_0000, 32'h3F80_0000, 1'b1, 32'h0000_0000, 4);
      run_op("diff30",         32'h3F80_0000, 32'h3080_0000, 1'b0, 32'h3F80_0000, 5);
      run_op("inf_minus_inf",  32'h7F80_0000, 32'hFF80_0000, 1'b0, 32'h7FC0_0000, 1);
      run_op("inf_plus_one",   32'h7F80_0000, 32'h3F80_0000, 1'b0, 32'h7F80_0000, 1);
      run_op("overflow",       32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 32'h7F80_0000, 4);
      run_op("nan_in",         32'h3F80_0000, 32'h7F80_0001, 1'b0, 32'h7FC0_0000, 1);
      run_op("neg_result",     32'h3F80_0000, 32'h4040_0000, 1'b1, 32'hC000_0000, 5);

      // Backpressure: result held, in_valid ignored while DONE
      out_ready = 1'b0;
      @(negedge clk);
      start_op(32'h3F80_0000, 32'h3F80_0000, 1'b0);
      wait_result(lat);
      check("bp_res", 64'(result), 64'(32'h4000_0000));
      check("bp_lat", 64'(lat), 64'd5);
      for (int i = 0; i < 10; i++) begin
         in_valid = (i % 2 == 0);
         num1 = $urandom;
         num2 = $urandom;
         @(negedge clk);
         check("bp_hold", 64'({out_valid, busy, in_ready, result}), 64'({3'b110, 32'h4000_0000}));
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      check("bp_release_idle", 64'({out_valid, busy, in_ready}), 64'(3'b001));
      num1 = 32'h4040_0000; num2 = 32'h3F80_0000; sel2 = 1'b1; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      check("bp_next_accepted", 64'({busy, in_ready}), 64'(2'b10));
      wait_result(lat);
      check("bp_next_res", 64'(result), 64'(32'h4000_0000));
      check("bp_next_lat", 64'(lat), 64'd5);
      @(negedge clk);

      // Reset during ALIGN abandons the operation
      start_op(32'h3F80_0000, 32'h3580_0000, 1'b0);
      repeat (3) @(negedge clk);
      rstn = 1'b0;
      #1;
      check("midop_reset", 64'({out_valid, busy, in_ready, result}), 64'({3'b001, 32'h0}));
      @(negedge clk);
      rstn = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      check("no_abandoned_result", 64'(seen), 64'd0);
      run_op("after_reset", 32'h3F80_0000, 32'h3F80_0000, 1'b0, 32'h4000_0000, 5);

      // Random operands against the reference model
      for (int i = 0; i < 40; i++) begin
         base = int'($urandom_range(1, 254));
         ra = rand_fp(base);
         rb = rand_fp(base);
         rs = 1'($urandom_range(0, 1));
         if (i % 8 == 0) begin
            rb = {ra[31] ^ 1'b1, ra[30:0]};
            rs = 1'b0;
         end
         ref_model(ra, rb, rs, rr, rl);
         run_op($sformatf("rand%0d", i), ra, rb, rs, rr, rl);
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
